// File: rtl/multicycle_control_if.sv
// Datapath <-> multi-cycle controller bundle.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       Jal;
    logic       RegWrite;
    logic       ExtFormat;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSrc;
    logic [3:0] State;
    logic       Fault;
    logic [1:0] FaultCode;

    modport master (
        input  Opcode, Funct, Zero, MemReady,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite,
        output MemtoReg, RegDst, Jal, RegWrite, ExtFormat,
        output ALUSrcA, ALUSrcB, ALUOp, PCSrc,
        output State, Fault, FaultCode
    );

    modport slave (
        output Opcode, Funct, Zero, MemReady,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite,
        input  MemtoReg, RegDst, Jal, RegWrite, ExtFormat,
        input  ALUSrcA, ALUSrcB, ALUOp, PCSrc,
        input  State, Fault, FaultCode
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-ready stalls,
// wait timeout and illegal-instruction trap.
module multicycle_control #(
    parameter int unsigned MAX_WAIT = 255
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        LWWB    = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        JR      = 4'd10,
        FAULT   = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1000;
    localparam logic [7:0] LIMIT  = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [1:0] fault_code;

    logic       rtype;
    logic       is_alu;
    logic       is_shift;
    logic       is_jr;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic       ext_sign;
    logic [3:0] alu_op;
    logic       mem_state;
    logic       timeout;

    assign rtype  = bus.Opcode == 6'h00;
    assign is_lw  = bus.Opcode == 6'h23;
    assign is_sw  = bus.Opcode == 6'h2b;
    assign is_beq = bus.Opcode == 6'h04;
    assign is_bne = bus.Opcode == 6'h05;
    assign is_j   = bus.Opcode == 6'h02;
    assign is_jal = bus.Opcode == 6'h03;
    assign ext_sign = is_lw | is_sw | is_beq | is_bne
                    | (bus.Opcode == 6'h08);

    always_comb begin
        alu_op   = OP_ADD;
        is_alu   = 1'b0;
        is_shift = 1'b0;
        is_jr    = 1'b0;
        if (rtype) begin
            case (bus.Funct)
                6'h20: begin is_alu = 1'b1; alu_op = OP_ADD; end
                6'h22: begin is_alu = 1'b1; alu_op = OP_SUB; end
                6'h24: begin is_alu = 1'b1; alu_op = OP_AND; end
                6'h25: begin is_alu = 1'b1; alu_op = OP_OR;  end
                6'h26: begin is_alu = 1'b1; alu_op = OP_XOR; end
                6'h2a: begin is_alu = 1'b1; alu_op = OP_SLT; end
                6'h00: begin
                    is_alu = 1'b1; is_shift = 1'b1; alu_op = OP_SLL;
                end
                6'h02: begin
                    is_alu = 1'b1; is_shift = 1'b1; alu_op = OP_SRL;
                end
                6'h03: begin
                    is_alu = 1'b1; is_shift = 1'b1; alu_op = OP_SRA;
                end
                6'h08: is_jr = 1'b1;
                default: ;
            endcase
        end else begin
            case (bus.Opcode)
                6'h08: begin is_alu = 1'b1; alu_op = OP_ADD; end
                6'h0c: begin is_alu = 1'b1; alu_op = OP_AND; end
                6'h0d: begin is_alu = 1'b1; alu_op = OP_OR;  end
                6'h0e: begin is_alu = 1'b1; alu_op = OP_XOR; end
                6'h0a: begin is_alu = 1'b1; alu_op = OP_SLT; end
                6'h0f: begin is_alu = 1'b1; alu_op = OP_LUI; end
                default: ;
            endcase
        end
    end

    assign mem_state = state == FETCH || state == MEMRD
                    || state == MEMWR;
    // MemReady on the limit cycle wins over the timeout
    assign timeout = mem_state && !bus.MemReady
                  && wait_cnt == LIMIT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            fault_code <= 2'd0;
        end else begin
            wait_cnt <= '0;
            if (mem_state && !bus.MemReady)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout) begin
                state      <= FAULT;
                fault_code <= 2'd2;
            end else begin
                case (state)
                    FETCH:   if (bus.MemReady) state <= DECODE;
                    DECODE: begin
                        unique case (1'b1)
                            is_lw | is_sw:   state <= MEMADDR;
                            is_alu:          state <= EXEC;
                            is_beq | is_bne: state <= BRANCH;
                            is_j | is_jal:   state <= JUMP;
                            is_jr:           state <= JR;
                            default: begin
                                state      <= FAULT;
                                fault_code <= 2'd1;
                            end
                        endcase
                    end
                    MEMADDR: state <= is_lw ? MEMRD : MEMWR;
                    MEMRD:   if (bus.MemReady) state <= LWWB;
                    MEMWR:   if (bus.MemReady) state <= FETCH;
                    EXEC:    state <= ALUWB;
                    FAULT:   state <= FAULT;
                    default: state <= FETCH;
                endcase
            end
        end
    end

    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegDst    = 1'b0;
        bus.Jal       = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ExtFormat = 1'b0;
        bus.ALUSrcA   = 2'd0;
        bus.ALUSrcB   = 2'd0;
        bus.ALUOp     = 4'd0;
        bus.PCSrc     = 2'd0;
        if (!reset) begin
            bus.ExtFormat = ext_sign;
            case (state)
                FETCH: begin
                    bus.ExtFormat = 1'b0;
                    bus.MemRead   = 1'b1;
                    bus.ALUSrcB   = 2'd1;
                    bus.ALUOp     = OP_ADD;
                    bus.PCWrite   = bus.MemReady;
                    bus.IRWrite   = bus.MemReady;
                end
                DECODE: begin
                    bus.ExtFormat = 1'b1;
                    bus.ALUSrcB   = 2'd3;
                    bus.ALUOp     = OP_ADD;
                end
                MEMADDR: begin
                    bus.ALUSrcA = 2'd1;
                    bus.ALUSrcB = 2'd2;
                    bus.ALUOp   = OP_ADD;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                LWWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                EXEC: begin
                    bus.ALUSrcA = is_shift ? 2'd2 : 2'd1;
                    bus.ALUSrcB = rtype ? 2'd0 : 2'd2;
                    bus.ALUOp   = alu_op;
                end
                ALUWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = ~rtype;
                end
                BRANCH: begin
                    bus.ALUSrcA = 2'd1;
                    bus.ALUOp   = OP_SUB;
                    bus.PCSrc   = 2'd1;
                    bus.PCWrite = (is_beq & bus.Zero)
                                | (is_bne & ~bus.Zero);
                end
                JUMP: begin
                    bus.PCSrc    = 2'd3;
                    bus.PCWrite  = 1'b1;
                    bus.Jal      = is_jal;
                    bus.RegWrite = is_jal;
                end
                JR: begin
                    bus.PCSrc   = 2'd2;
                    bus.PCWrite = 1'b1;
                end
                default: bus.ExtFormat = 1'b0;
            endcase
        end
    end

    assign bus.State     = state;
    assign bus.Fault     = state == FAULT;
    assign bus.FaultCode = fault_code;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MAX_WAIT = 4).
// Each task checks its own scenario with literal expectations.
module tb_multicycle_control;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    multicycle_control_if bus ();

    multicycle_control #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h20;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        reset = 1'b1;
        #3;
        vectors++;
        if (bus.State !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_state: got %0d want 0", bus.State);
        end
        vectors++;
        if ({bus.Fault, bus.FaultCode} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_fault: got %b want 000",
                     {bus.Fault, bus.FaultCode});
        end
        vectors++;
        if ({bus.MemRead, bus.PCWrite, bus.IRWrite} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_strobes: got %b want 000",
                     {bus.MemRead, bus.PCWrite, bus.IRWrite});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.MemRead, bus.PCWrite, bus.IRWrite,
             bus.ALUSrcB, bus.ALUOp} !== 9'b111_01_0010) begin
            miscompares++;
            $display("FAIL fetch_out: got %b want 111010010",
                     {bus.MemRead, bus.PCWrite, bus.IRWrite,
                      bus.ALUSrcB, bus.ALUOp});
        end
    endtask

    task automatic test_add;
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h20;
        bus.MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.State !== exp_st[i]) begin
                miscompares++;
                $display("FAIL add_state%0d: got %0d want %0d",
                         i, bus.State, exp_st[i]);
            end
            if (i == 2) begin
                vectors++;
                if ({bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA}
                    !== 8'b0010_00_01) begin
                    miscompares++;
                    $display("FAIL add_exec: got %b want 00100001",
                             {bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA});
                end
            end
            if (i == 3) begin
                vectors++;
                if ({bus.RegWrite, bus.RegDst, bus.MemtoReg}
                    !== 3'b100) begin
                    miscompares++;
                    $display("FAIL add_wb: got %b want 100",
                             {bus.RegWrite, bus.RegDst, bus.MemtoReg});
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_sll;
        bus.Opcode = 6'h00;
        bus.Funct  = 6'h00;
        tick();
        tick();
        vectors++;
        if ({bus.State, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB}
            !== 12'b0110_0100_10_00) begin
            miscompares++;
            $display("FAIL sll_exec: got %b want 011001001000",
                     {bus.State, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB});
        end
        tick();
        tick();
    endtask

    task automatic test_ori;
        bus.Opcode = 6'h0d;
        bus.Funct  = 6'h3f;
        tick();
        tick();
        vectors++;
        if ({bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ExtFormat}
            !== 9'b0001_01_10_0) begin
            miscompares++;
            $display("FAIL ori_exec: got %b want 000101100",
                     {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB,
                      bus.ExtFormat});
        end
        tick();
        vectors++;
        if ({bus.State, bus.RegWrite, bus.RegDst} !== 6'b0111_11) begin
            miscompares++;
            $display("FAIL ori_wb: got %b want 011111",
                     {bus.State, bus.RegWrite, bus.RegDst});
        end
        tick();
    endtask

    task automatic test_lw_stall;
        bus.Opcode   = 6'h23;
        bus.MemReady = 1'b1;
        tick();
        vectors++;
        if ({bus.State, bus.ExtFormat, bus.ALUSrcB} !== 7'b0001_1_11) begin
            miscompares++;
            $display("FAIL lw_decode: got %b want 0001111",
                     {bus.State, bus.ExtFormat, bus.ALUSrcB});
        end
        tick();
        vectors++;
        if ({bus.State, bus.ALUSrcA, bus.ALUSrcB, bus.ExtFormat}
            !== 9'b0010_01_10_1) begin
            miscompares++;
            $display("FAIL lw_addr: got %b want 001001101",
                     {bus.State, bus.ALUSrcA, bus.ALUSrcB,
                      bus.ExtFormat});
        end
        bus.MemReady = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                bus.MemReady = 1'b1;
                #1;
            end
            vectors++;
            if ({bus.State, bus.MemRead, bus.IorD} !== 6'b0011_11) begin
                miscompares++;
                $display("FAIL lw_memrd%0d: got %b want 001111",
                         k, {bus.State, bus.MemRead, bus.IorD});
            end
            tick();
        end
        vectors++;
        if ({bus.State, bus.RegWrite, bus.MemtoReg, bus.RegDst,
             bus.Fault} !== 8'b0100_111_0) begin
            miscompares++;
            $display("FAIL lw_wb: got %b want 01001110",
                     {bus.State, bus.RegWrite, bus.MemtoReg,
                      bus.RegDst, bus.Fault});
        end
        tick();
        vectors++;
        if (bus.State !== 4'd0) begin
            miscompares++;
            $display("FAIL lw_done: got %0d want 0", bus.State);
        end
    endtask

    task automatic test_sw;
        bus.Opcode   = 6'h2b;
        bus.MemReady = 1'b1;
        tick();
        tick();
        tick();
        vectors++;
        if ({bus.State, bus.MemWrite, bus.IorD, bus.MemRead}
            !== 7'b0101_110) begin
            miscompares++;
            $display("FAIL sw_memwr: got %b want 0101110",
                     {bus.State, bus.MemWrite, bus.IorD, bus.MemRead});
        end
        tick();
    endtask

    task automatic test_branch;
        bus.Opcode   = 6'h04;
        bus.Zero     = 1'b1;
        bus.MemReady = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.State, bus.PCWrite, bus.PCSrc, bus.ALUOp}
            !== 11'b1000_1_01_0110) begin
            miscompares++;
            $display("FAIL beq_taken: got %b want 10001010110",
                     {bus.State, bus.PCWrite, bus.PCSrc, bus.ALUOp});
        end
        tick();
        bus.Opcode = 6'h05;
        tick();
        tick();
        vectors++;
        if ({bus.State, bus.PCWrite} !== 5'b1000_0) begin
            miscompares++;
            $display("FAIL bne_zero: got %b want 10000",
                     {bus.State, bus.PCWrite});
        end
        bus.Zero = 1'b0;
        #1;
        vectors++;
        if (bus.PCWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL bne_nonzero: got %b want 1", bus.PCWrite);
        end
        tick();
    endtask

    task automatic test_jal;
        bus.Opcode = 6'h03;
        tick();
        tick();
        vectors++;
        if ({bus.State, bus.PCSrc, bus.PCWrite, bus.Jal, bus.RegWrite}
            !== 9'b1001_11_111) begin
            miscompares++;
            $display("FAIL jal_jump: got %b want 100111111",
                     {bus.State, bus.PCSrc, bus.PCWrite, bus.Jal,
                      bus.RegWrite});
        end
        tick();
        bus.Opcode = 6'h00;
        bus.Funct  = 6'h08;
        tick();
        tick();
        vectors++;
        if ({bus.State, bus.PCSrc, bus.PCWrite, bus.Jal}
            !== 8'b1010_10_10) begin
            miscompares++;
            $display("FAIL jr: got %b want 10101010",
                     {bus.State, bus.PCSrc, bus.PCWrite, bus.Jal});
        end
        tick();
    endtask

    task automatic test_illegal(input logic [5:0] op,
                                input logic [5:0] fn);
        apply_reset();
        bus.Opcode   = op;
        bus.Funct    = fn;
        bus.MemReady = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({bus.State, bus.Fault, bus.FaultCode, bus.MemRead,
                 bus.PCWrite} !== 9'b1100_1_01_00) begin
                miscompares++;
                $display("FAIL illegal_%h_%h: got %b want 110010100",
                         op, fn, {bus.State, bus.Fault, bus.FaultCode,
                                  bus.MemRead, bus.PCWrite});
            end
            tick();
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.State, bus.Fault, bus.FaultCode} !== 7'd0) begin
            miscompares++;
            $display("FAIL illegal_clear: got %b want 0000000",
                     {bus.State, bus.Fault, bus.FaultCode});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_timeout;
        apply_reset();
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h20;
        bus.MemReady = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({bus.State, bus.PCWrite, bus.Fault} !== 6'b0000_00) begin
                miscompares++;
                $display("FAIL to_wait%0d: got %b want 000000",
                         k, {bus.State, bus.PCWrite, bus.Fault});
            end
            tick();
        end
        vectors++;
        if ({bus.State, bus.Fault, bus.FaultCode} !== 7'b1100_1_10) begin
            miscompares++;
            $display("FAIL to_fault: got %b want 1100110",
                     {bus.State, bus.Fault, bus.FaultCode});
        end
        apply_reset();
        bus.MemReady = 1'b0;
        tick();
        tick();
        tick();
        bus.MemReady = 1'b1;
        #1;
        vectors++;
        if ({bus.State, bus.PCWrite, bus.IRWrite} !== 6'b0000_11) begin
            miscompares++;
            $display("FAIL to_edge_fetch: got %b want 000011",
                     {bus.State, bus.PCWrite, bus.IRWrite});
        end
        tick();
        vectors++;
        if ({bus.State, bus.Fault} !== 5'b0001_0) begin
            miscompares++;
            $display("FAIL to_edge_decode: got %b want 00010",
                     {bus.State, bus.Fault});
        end
    endtask

    task automatic test_abort;
        apply_reset();
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h22;
        bus.MemReady = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.State, bus.RegWrite, bus.MemRead, bus.PCWrite}
            !== 7'd0) begin
            miscompares++;
            $display("FAIL abort: got %b want 0000000",
                     {bus.State, bus.RegWrite, bus.MemRead,
                      bus.PCWrite});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_sll();
        test_ori();
        test_lw_stall();
        test_sw();
        test_branch();
        test_jal();
        test_illegal(6'h3f, 6'h20);
        test_illegal(6'h00, 6'h01);
        test_timeout();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle FSM controller for the MIPS datapath, replacing the single-cycle combinational decoder.
- Each instruction is sequenced over 3-5 states using shared memory, ALU and ALUOut/IR/PC registers.
- Stalls on a memory ready handshake.
- Traps illegal instructions and memory timeouts into a terminal fault state.

Parameters:
- MAX_WAIT, 255: cycles to wait for MemReady in a memory state before a timeout fault (1..255).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- Opcode  input  6  IR[31:26]; stable from DECODE onward
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  load PC
- IRWrite  output  1  load IR
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- MemtoReg  output  1  register write data: 1 = MDR, 0 = ALUOut
- RegDst  output  1  write register: 0 = rd, 1 = rt
- Jal  output  1  force $31 as destination, write PC
- RegWrite  output  1  register file write
- ExtFormat  output  1  immediate extension: 0 = zero, 1 = sign
- ALUSrcA  output  2  0 = PC, 1 = rs, 2 = shamt
- ALUSrcB  output  2  0 = rt, 1 = constant 4, 2 = ext imm, 3 = ext imm<<2
- ALUOp  output  4  ALU operation code
- PCSrc  output  2  0 = ALU result, 1 = ALUOut, 2 = rs, 3 = {PC[31:28], addr, 2'b00}
- State  output  4  current state (debug)
- Fault  output  1  fault state reached
- FaultCode  output  2  1 = illegal instruction, 2 = memory timeout

Behaviour:
- Reset (async): state FETCH, wait counter 0, Fault 0, FaultCode 0.
- All outputs are Moore decodes of the state plus IR fields, except PCWrite/IRWrite in FETCH (gated by MemReady) and PCWrite in BRANCH (gated by Zero).
- Any strobe not listed for a state is 0.
- ALUOp encoding:
  - add 0010, sub 0110, and 0000, or 0001, xor 0011
  - slt 0111, sll 0100, srl 0101, sra 1001, lui 1000
- Supported instructions:
  - R-type (Opcode 00) by Funct: add 20, sub 22, and 24, or 25, xor 26, slt 2a, sll 00, srl 02, sra 03, jr 08.
  - I/J-type by Opcode: addi 08, andi 0c, ori 0d, xori 0e, slti 0a, lui 0f, lw 23, sw 2b, beq 04, bne 05, j 02, jal 03.
  - Anything else is illegal.
- ExtFormat = 1 in DECODE, and for addi/lw/sw/beq/bne in later states; 0 otherwise.
- States (encoding 0..12, driven on State):
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSrc=0; PCWrite=IRWrite=MemReady. Goes to DECODE on MemReady, else holds.
  - DECODE(1): ALUSrcA=0, ALUSrcB=3, add (branch target into ALUOut). Next state by class:
    - lw/sw -> MEMADDR
    - R-ALU/I-ALU -> EXEC
    - beq/bne -> BRANCH
    - j/jal -> JUMP
    - jr -> JR
    - illegal -> FAULT with code 1
  - MEMADDR(2): ALUSrcA=1, ALUSrcB=2, add. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): MemRead=1, IorD=1; to LWWB on MemReady.
  - LWWB(4): RegWrite=1, MemtoReg=1, RegDst=1; to FETCH.
  - MEMWR(5): MemWrite=1, IorD=1; to FETCH on MemReady.
  - EXEC(6): ALUSrcA=2 for sll/srl/sra, else 1; ALUSrcB=0 for R-type, else 2; ALUOp per instruction; to ALUWB.
  - ALUWB(7): RegWrite=1, MemtoReg=0, RegDst=~RType; to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=0, sub, PCSrc=1; PCWrite = beq&Zero | bne&~Zero; to FETCH.
  - JUMP(9): PCSrc=3, PCWrite=1; for jal also Jal=1, RegWrite=1 (PC already +4); to FETCH.
  - JR(10): PCSrc=2, PCWrite=1; to FETCH.
  - FAULT(12): Fault=1; FaultCode held; all strobes 0; terminal until reset.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Clears on entry to a memory state and on MemReady.
  - Increments each cycle MemReady=0.
  - When it reaches MAX_WAIT with MemReady still 0 -> FAULT, code 2.
  - MemReady in the same cycle the limit is reached wins: normal transition, no fault.
- Reset asserted mid-instruction aborts it immediately; no strobe is asserted after reset rises.

Test Plan:
- add $3,$1,$2 with MemReady always 1:
  - States 0,1,6,7,0.
  - EXEC: ALUOp=0010, ALUSrcB=0.
  - ALUWB: RegWrite=1, RegDst=0.
  - Exactly 4 cycles per instruction.
- lw with MemReady low for 3 cycles in MEMRD:
  - MEMRD held 4 cycles.
  - LWWB: MemtoReg=1, RegDst=1.
  - Fault stays 0.
- beq with Zero=1 then bne with Zero=1:
  - beq: PCWrite=1, PCSrc=1.
  - bne: PCWrite=0.
- jal:
  - JUMP: PCSrc=3, PCWrite=1, Jal=1, RegWrite=1.
- Opcode 6'h3f, and R-type Funct 6'h01:
  - FAULT after DECODE, FaultCode=1.
  - Held until reset; then State=0.
- MAX_WAIT=4, MemReady stuck low in FETCH:
  - FAULT after 4 wait cycles, FaultCode=2.
  - Repeat with MemReady rising exactly on the 4th cycle: goes to DECODE, no fault.
